data_shifter_right_sat: RTL and testbench
=========================================

# data_shifter_right_sat

Receive-side counterpart of the left shifter. It narrows 24-bit signed samples from the processing path back to 16-bit signed audio, applying an arithmetic right shift with round-half-up and saturation. It decouples producer and consumer with a 2-entry output buffer and valid/ready handshakes. It sits between the 24-bit DSP chain and the 16-bit DAC/output path, on the 40 kHz sample clock domain.

## Interface
- IN_W, 24, input sample width (signed)
- OUT_W, 16, output sample width (signed)
- SHIFT, 8, right-shift amount; IN_W − SHIFT + 1 ≥ OUT_W
- CNT_W, 16, saturation event counter width
- clk  input  1  sample clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- enn  input  1  block enable; low = flush and hold idle
- in_data  input  IN_W  signed sample
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept; registered
- out_data  output  OUT_W  signed narrowed sample
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts
- clr_sat  input  1  one-cycle pulse; clears sat_flag and sat_count
- sat_flag  output  1  sticky, set on any clipped sample
- sat_count  output  CNT_W  number of clipped samples, saturating

## Operation
- Arithmetic, per accepted sample:
  - sum = sext(in_data, IN_W+1) + 2^(SHIFT−1)
  - q = sum >>> SHIFT, giving an (IN_W+1−SHIFT)-bit signed value
  - if q > 2^(OUT_W−1)−1, result = 32767 and the sample is marked sat
  - if q < −2^(OUT_W−1), result = −32768 and the sample is marked sat
  - otherwise result = q[OUT_W−1:0]
- Accept condition: in_valid && in_ready. Release condition: out_valid && out_ready.
- Buffer: 2-entry FIFO of results.
  - out_data/out_valid come from the head entry.
  - count ∈ {0,1,2}.
  - Push and pop in the same cycle leave count unchanged and preserve order.
- in_ready = enn && (count < 2), driven from registered count only, with no combinational path from out_ready.
- enn low at an edge:
  - buffer flushed (count = 0), so out_valid = 0 and out_data = 0 on the following cycle
  - any in_valid in that cycle is dropped
  - sat_flag and sat_count are held
- Saturation statistics:
  - each accepted sat sample sets sat_flag and increments sat_count
  - sat_count stops at 2^CNT_W−1
  - clr_sat coincident with an accepted sat sample: result is sat_flag = 1, sat_count = 1
  - clr_sat alone: both cleared

## Timing
- Reset values: in_ready = 0, out_valid = 0, out_data = 0, sat_flag = 0, sat_count = 0, count = 0. in_ready rises on the first edge after rst deasserts with enn = 1.
- Latency: a sample accepted at edge N appears on out_data with out_valid = 1 after edge N, when the buffer was empty.
- Throughput: 1 sample/cycle sustained while out_ready = 1.
- Stall: with out_ready = 0, two samples are buffered. in_ready falls after the edge that fills entry 2.
- Hold: out_data and out_valid stay stable while out_valid && !out_ready. The head never changes without a pop.
- Reset asserted mid-stream: all state clears immediately and buffered samples are lost. No partial output after rst deasserts.

## Structure
- Package shifter_pkg holds:
  - IN_W/OUT_W/SHIFT defaults
  - ROUND_C = 2^(SHIFT−1)
  - OUT_MAX = 32767 and OUT_MIN = −32768 as OUT_W-bit signed constants
  - CNT_W default
- Sub-module sample_fifo2: 2-entry synchronous FIFO with async active-high reset, synchronous flush input, push/pop, and count output.
- The top level contains the round/shift/saturate datapath, handshake glue and saturation counters.

## Test plan
- Pass-through: enn = 1, out_ready = 1. Send in 0x04D200, then 0xE9D200 → out 0x04D2 (1234) then 0xE9D2 (−5678), one cycle after each accept, sat_flag = 0.
- Rounding: in 0x04D280 → 0x04D3. In 0xFFFF80 → 0x0000. In 0xFFFF7F → 0xFFFF.
- Saturation:
  - in 0x7FFFFF → 0x7FFF, sat_flag = 1, sat_count = 1
  - in 0x800000 → 0x8000, sat_count unchanged
  - then clr_sat together with a 0x7FFFFF accept → sat_flag = 1, sat_count = 1
- Backpressure:
  - out_ready = 0, send 3 samples (10, 20, 30 shifted left 8) → in_ready drops after the 2nd, 3rd waits
  - release out_ready → outputs 10, 20, 30 in order, no loss or duplication
- Enable: with 2 entries buffered, drop enn for one cycle → out_valid = 0, out_data = 0, in_ready = 0. Re-enable → next sample passes with 1-cycle latency.
- Async reset mid-stream: assert rst between edges with buffered data → all outputs reach reset values before the next edge.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared constants and types for the 24-to-16-bit right shifter with rounding and saturation.
package shifter_pkg;

  localparam int DEFAULT_IN_W  = 24;
  localparam int DEFAULT_OUT_W = 16;
  localparam int DEFAULT_SHIFT = 8;
  localparam int DEFAULT_CNT_W = 16;

  // Half an output LSB, added before the shift so that truncation rounds half-up.
  localparam logic [DEFAULT_IN_W:0] ROUND_C = (DEFAULT_IN_W + 1)'(2 ** (DEFAULT_SHIFT - 1));

  localparam logic signed [DEFAULT_OUT_W-1:0] OUT_MAX = 16'sh7FFF;
  localparam logic signed [DEFAULT_OUT_W-1:0] OUT_MIN = 16'sh8000;

  // Buffer operation for one cycle, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/data_shifter_right_sat_if.sv
// Valid/ready sample stream in and out of the shifter; master is the surrounding path, slave the block.
interface data_shifter_right_sat_if
  import shifter_pkg::*;
#(
  parameter int IN_W  = DEFAULT_IN_W,
  parameter int OUT_W = DEFAULT_OUT_W
);

  logic signed [IN_W-1:0]  in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/sample_fifo2.sv
// Two-entry FIFO kept as a shift pair: entry 0 is always the head, so no read pointer is needed.
module sample_fifo2
  import shifter_pkg::*;
#(
  parameter int W = DEFAULT_OUT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] entry0;
  logic [W-1:0] entry1;
  logic         pop_ok;
  logic         push_ok;
  fifo_op_e     op;

  // A pop on empty is ignored; a push on full only lands if a pop frees the slot.
  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign op      = fifo_op_e'({push_ok, pop_ok});
  assign head    = entry0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: with only two entries the storage is reset like any other flop;
      // a deep RAM-backed buffer would leave its array unreset.
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (count == 2'd0) entry0 <= din;
          else               entry1 <= din;
          count <= count + 2'd1;
        end
        OP_POP: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        OP_BOTH: begin
          if (count == 2'd1) begin
            entry0 <= din;
          end else begin
            entry0 <= entry1;
            entry1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/data_shifter_right_sat.sv
// Narrows signed samples with round-half-up right shift and saturation, buffered behind a
// registered-ready 2-entry FIFO, and keeps sticky/counted statistics of clipped samples.
module data_shifter_right_sat
  import shifter_pkg::*;
#(
  parameter int IN_W  = DEFAULT_IN_W,
  parameter int OUT_W = DEFAULT_OUT_W,
  parameter int SHIFT = DEFAULT_SHIFT,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enn,
  data_shifter_right_sat_if.slave bus,
  input  logic                   clr_sat,
  output logic                   sat_flag,
  output logic [CNT_W-1:0]       sat_count
);

  localparam int Q_W = IN_W + 1 - SHIFT;

  localparam logic signed [IN_W:0]    RND    = (IN_W + 1)'(2 ** (SHIFT - 1));
  localparam logic signed [Q_W-1:0]   Q_MAX  = Q_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [Q_W-1:0]   Q_MIN  = Q_W'(-(2 ** (OUT_W - 1)));
  localparam logic [OUT_W-1:0]        SAT_HI = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]        SAT_LO = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0]  sum;
  logic signed [Q_W-1:0] q;
  logic [OUT_W-1:0]      result;
  logic                  is_sat;

  logic                  accept;
  logic                  pop;
  logic                  out_valid;
  logic [OUT_W-1:0]      head;
  logic [1:0]            count;
  logic [1:0]            count_next;
  logic                  in_ready_q;

  // One extra bit of headroom keeps the rounding add from wrapping at the positive rail.
  assign sum = {bus.in_data[IN_W-1], bus.in_data} + RND;
  assign q   = Q_W'(sum >>> SHIFT);

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    result = q[OUT_W-1:0];
    is_sat = 1'b0;
    if (q > Q_MAX) begin
      result = SAT_HI;
      is_sat = 1'b1;
    end else if (q < Q_MIN) begin
      result = SAT_LO;
      is_sat = 1'b1;
    end
  end

  // enn also gates accept: in_ready is a cycle old and must not admit a sample during a flush.
  assign accept    = bus.in_valid && in_ready_q && enn;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && bus.out_ready;

  sample_fifo2 #(
    .W (OUT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (!enn),
    .push  (accept),
    .pop   (pop),
    .din   (result),
    .head  (head),
    .count (count)
  );

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? head : '0;
  assign bus.in_ready  = in_ready_q;

  // Occupancy after this edge; in_ready is registered from it so out_ready never reaches in_ready combinationally.
  always_comb begin
    count_next = count;
    if (!enn) begin
      count_next = 2'd0;
    end else begin
      case ({accept, pop})
        2'b10:   count_next = count + 2'd1;
        2'b01:   count_next = count - 2'd1;
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= enn && (count_next < 2'd2);
    end
  end

  // A clear coincident with a clipped sample counts that sample as the first of a new run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag  <= 1'b0;
      sat_count <= '0;
    end else if (accept && is_sat) begin
      sat_flag <= 1'b1;
      if (clr_sat)              sat_count <= CNT_W'(1);
      else if (sat_count != '1) sat_count <= sat_count + 1'b1;
    end else if (clr_sat) begin
      sat_flag  <= 1'b0;
      sat_count <= '0;
    end
  end

endmodule

// File: tb/tb_data_shifter_right_sat.sv
// Self-checking bench for data_shifter_right_sat: directed vector table, handshake corner
// sequences, and a randomized run against an arithmetic reference model.
module tb_data_shifter_right_sat;

  logic        clk = 1'b0;
  logic        rst;
  logic        enn;
  logic        clr_sat;
  logic        sat_flag;
  logic [15:0] sat_count;

  always #5 clk = ~clk;

  data_shifter_right_sat_if #(.IN_W(24), .OUT_W(16)) bus ();

  data_shifter_right_sat #(
    .IN_W  (24),
    .OUT_W (16),
    .SHIFT (8),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enn       (enn),
    .bus       (bus),
    .clr_sat   (clr_sat),
    .sat_flag  (sat_flag),
    .sat_count (sat_count)
  );

  typedef struct {
    logic [23:0] din;
    logic [15:0] dout;
    bit          sat;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Inputs are changed on the falling edge; outputs are checked on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_stream(input string tag, input bit v, input logic [15:0] d, input bit rdy);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".out_data"}, {16'h0, bus.out_data}, v ? {16'h0, d} : 32'h0);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
  endtask

  // Reference: round(x / 256) with halves going up, clamped to the 16-bit signed range.
  function automatic logic [16:0] ref_narrow(input logic [23:0] x);
    int v;
    int s;
    int q;
    logic [15:0] lo;
    v = int'($signed(x));
    s = v + 128;
    q = s / 256;
    if (s < 0 && (s % 256) != 0) q = q - 1;
    if (q > 32767)  return {1'b1, 16'h7FFF};
    if (q < -32768) return {1'b1, 16'h8000};
    lo = q[15:0];
    return {1'b0, lo};
  endfunction

  initial begin
    vec_t        vecs [12];
    int          exp_cnt;
    logic [15:0] mq [$];
    bit          m_rdy;
    bit          m_flag;
    int          m_cnt;

    vecs[0]  = '{24'h04D200, 16'h04D2, 1'b0};
    vecs[1]  = '{24'hE9D200, 16'hE9D2, 1'b0};
    vecs[2]  = '{24'h04D280, 16'h04D3, 1'b0};
    vecs[3]  = '{24'hFFFF80, 16'h0000, 1'b0};
    vecs[4]  = '{24'hFFFF7F, 16'hFFFF, 1'b0};
    vecs[5]  = '{24'h7FFFFF, 16'h7FFF, 1'b1};
    vecs[6]  = '{24'h800000, 16'h8000, 1'b0};
    vecs[7]  = '{24'h7FFF7F, 16'h7FFF, 1'b0};
    vecs[8]  = '{24'h7FFF80, 16'h7FFF, 1'b1};
    vecs[9]  = '{24'h80007F, 16'h8000, 1'b0};
    vecs[10] = '{24'h000080, 16'h0001, 1'b0};
    vecs[11] = '{24'h00007F, 16'h0000, 1'b0};

    rst           = 1'b1;
    enn           = 1'b1;
    clr_sat       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state, and in_ready rising one edge after release.
    repeat (2) @(negedge clk);
    check_stream("reset", 1'b0, 16'h0, 1'b0);
    check("reset.sat_flag", 32'(sat_flag), 32'h0);
    check("reset.sat_count", 32'(sat_count), 32'h0);
    rst = 1'b0;
    step();
    check("post_reset.in_ready", 32'(bus.in_ready), 32'h1);

    // Directed vectors in pass-through: each result appears one edge after its accept.
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vecs[i].din;
      step();
      if (vecs[i].sat) exp_cnt++;
      check_stream($sformatf("vec%0d", i), 1'b1, vecs[i].dout, 1'b1);
      check($sformatf("vec%0d.sat_flag", i), 32'(sat_flag), 32'(exp_cnt != 0));
      check($sformatf("vec%0d.sat_count", i), 32'(sat_count), 32'(exp_cnt));
    end
    bus.in_valid = 1'b0;
    step();
    check("drain.out_valid", 32'(bus.out_valid), 32'h0);

    // clr_sat coincident with a clipped accept, then clr_sat alone.
    clr_sat      = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 24'h7FFFFF;
    step();
    check("clr_with_sat.sat_flag", 32'(sat_flag), 32'h1);
    check("clr_with_sat.sat_count", 32'(sat_count), 32'h1);
    bus.in_valid = 1'b0;
    step();
    clr_sat = 1'b0;
    check("clr_alone.sat_flag", 32'(sat_flag), 32'h0);
    check("clr_alone.sat_count", 32'(sat_count), 32'h0);

    // sat_count stops at its maximum.
    bus.in_valid = 1'b1;
    bus.in_data  = 24'h7FFFFF;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("sat_count_near_max", 32'(sat_count), 32'd65534);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("sat_count_at_max", 32'(sat_count), 32'd65535);
    clr_sat = 1'b1;
    step();
    clr_sat = 1'b0;
    check("sat_count_cleared", 32'(sat_count), 32'h0);
    check_stream("after_max", 1'b0, 16'h0, 1'b1);

    // Backpressure: two samples buffered, third waits, release drains 10, 20, 30 in order.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 24'd10 << 8;
    step();
    check_stream("bp_first", 1'b1, 16'd10, 1'b1);
    bus.in_data = 24'd20 << 8;
    step();
    check_stream("bp_full", 1'b1, 16'd10, 1'b0);
    bus.in_data = 24'd30 << 8;
    step();
    check_stream("bp_hold", 1'b1, 16'd10, 1'b0);
    bus.out_ready = 1'b1;
    step();
    check_stream("bp_out20", 1'b1, 16'd20, 1'b1);
    step();
    check_stream("bp_out30", 1'b1, 16'd30, 1'b1);
    bus.in_valid = 1'b0;
    step();
    check_stream("bp_empty", 1'b0, 16'h0, 1'b1);

    // Enable low for one cycle flushes two buffered samples and drops the offered one.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 24'd100 << 8;
    step();
    bus.in_data = 24'd200 << 8;
    step();
    enn         = 1'b0;
    bus.in_data = 24'd300 << 8;
    step();
    check_stream("enn_low", 1'b0, 16'h0, 1'b0);
    enn          = 1'b1;
    bus.in_valid = 1'b0;
    step();
    check_stream("enn_back", 1'b0, 16'h0, 1'b1);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 24'd400 << 8;
    step();
    check_stream("enn_pass", 1'b1, 16'd400, 1'b1);
    bus.in_valid = 1'b0;
    step();

    // Asynchronous reset between edges with two samples buffered and sat_flag set.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 24'h7FFFFF;
    step();
    bus.in_data = 24'h001400;
    step();
    bus.in_valid = 1'b0;
    check("pre_rst.sat_flag", 32'(sat_flag), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_stream("async_rst", 1'b0, 16'h0, 1'b0);
    check("async_rst.sat_flag", 32'(sat_flag), 32'h0);
    check("async_rst.sat_count", 32'(sat_count), 32'h0);
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check_stream("after_rst", 1'b0, 16'h0, 1'b1);

    // Randomized traffic against the reference model.
    m_rdy  = 1'b1;
    m_flag = 1'b0;
    m_cnt  = 0;
    for (int n = 0; n < 600; n++) begin
      logic [23:0] d;
      logic [16:0] r;
      bit          acc;
      bit          pp;
      int          sel;
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      d = 24'h7FFF00 | 24'($urandom_range(0, 255));
      else if (sel == 1) d = 24'h800000 | 24'($urandom_range(0, 255));
      else               d = 24'($urandom);
      bus.in_data   = d;
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      enn           = ($urandom_range(0, 19) != 0);
      clr_sat       = ($urandom_range(0, 29) == 0);

      r   = ref_narrow(d);
      acc = bus.in_valid && m_rdy && enn;
      pp  = (mq.size() > 0) && bus.out_ready;
      if (!enn) begin
        mq.delete();
      end else begin
        if (pp) void'(mq.pop_front());
        if (acc) mq.push_back(r[15:0]);
      end
      if (acc && r[16]) begin
        m_flag = 1'b1;
        if (clr_sat)            m_cnt = 1;
        else if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else if (clr_sat) begin
        m_flag = 1'b0;
        m_cnt  = 0;
      end
      m_rdy = enn && (mq.size() < 2);

      step();
      check_stream($sformatf("rnd%0d", n), mq.size() > 0, (mq.size() > 0) ? mq[0] : 16'h0, m_rdy);
      check($sformatf("rnd%0d.sat_flag", n), 32'(sat_flag), 32'(m_flag));
      check($sformatf("rnd%0d.sat_count", n), 32'(sat_count), 32'(m_cnt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
